// File: rtl/mb_result_writer_pkg.sv
// Shared definitions for the macroblock result writer and the downstream
// bitstream writer: FSM encoding, beat geometry and header field layout.
package mb_result_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_t;

  // Beat geometry
  localparam int BEAT_W     = 1024;
  localparam int BEATS_FULL = 7;
  localparam int BEATS_SKIP = 1;
  localparam int BEAT_CNT_W = 3;
  localparam int AC_BEATS   = 4;
  localparam int UV_BEATS   = 2;

  // Header beat field layout (lsb offset / width)
  localparam int HDR_MB_IDX_LSB   = 0;
  localparam int HDR_MB_IDX_W     = 32;
  localparam int HDR_MODE_I16_LSB = 32;
  localparam int HDR_MODE_I16_W   = 32;
  localparam int HDR_MODE_I4_LSB  = 64;
  localparam int HDR_MODE_I4_W    = 128;
  localparam int HDR_MODE_UV_LSB  = 192;
  localparam int HDR_MODE_UV_W    = 32;
  localparam int HDR_SKIPPED_LSB  = 224;
  localparam int HDR_SKIPPED_W    = 8;
  localparam int HDR_MBTYPE_LSB   = 232;
  localparam int HDR_MBTYPE_W     = 8;
  localparam int HDR_NZ_LSB       = 240;
  localparam int HDR_NZ_W         = 32;
  localparam int HDR_DC_LSB       = 272;
  localparam int HDR_DC_W         = 256;

  // Assemble the header beat; bits above the dc_levels field stay zero.
  function automatic logic [BEAT_W-1:0] build_header(
    input logic [HDR_MB_IDX_W-1:0]   mb_idx,
    input logic [HDR_MODE_I16_W-1:0] mode_i16,
    input logic [HDR_MODE_I4_W-1:0]  mode_i4,
    input logic [HDR_MODE_UV_W-1:0]  mode_uv,
    input logic [HDR_SKIPPED_W-1:0]  skipped,
    input logic [HDR_MBTYPE_W-1:0]   mbtype,
    input logic [HDR_NZ_W-1:0]       nz,
    input logic [HDR_DC_W-1:0]       dc_levels
  );
    logic [BEAT_W-1:0] hdr;
    hdr = '0;
    hdr[HDR_MB_IDX_LSB   +: HDR_MB_IDX_W]   = mb_idx;
    hdr[HDR_MODE_I16_LSB +: HDR_MODE_I16_W] = mode_i16;
    hdr[HDR_MODE_I4_LSB  +: HDR_MODE_I4_W]  = mode_i4;
    hdr[HDR_MODE_UV_LSB  +: HDR_MODE_UV_W]  = mode_uv;
    hdr[HDR_SKIPPED_LSB  +: HDR_SKIPPED_W]  = skipped;
    hdr[HDR_MBTYPE_LSB   +: HDR_MBTYPE_W]   = mbtype;
    hdr[HDR_NZ_LSB       +: HDR_NZ_W]       = nz;
    hdr[HDR_DC_LSB       +: HDR_DC_W]       = dc_levels;
    return hdr;
  endfunction

endpackage

// File: rtl/mb_result_writer.sv
// Macroblock result writer: holds one result bundle and streams it to the
// output FIFO as 1024-bit beats (header, 4 luma AC beats, 2 chroma beats),
// counting macroblocks per frame and pulsing frame_done at frame end.
module mb_result_writer
  import mb_result_writer_pkg::*;
#(
  parameter int MB_CNT_W   = 20,
  parameter int SKIP_SHORT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic [MB_CNT_W-1:0] mb_total,
  input  logic                load,
  input  logic [31:0]         mode_i16,
  input  logic [127:0]        mode_i4,
  input  logic [31:0]         mode_uv,
  input  logic [255:0]        dc_levels,
  input  logic [4095:0]       ac_levels,
  input  logic [2047:0]       uv_levels,
  input  logic [7:0]          skipped,
  input  logic [7:0]          mbtype,
  input  logic [31:0]         nz,
  input  logic                fifo_full,
  output logic                ready,
  output logic                fifo_wr,
  output logic [BEAT_W-1:0]   data_out,
  output logic                frame_done,
  output logic                overrun
);

  wr_state_t             state_reg;
  logic [MB_CNT_W-1:0]   mb_total_reg;
  logic [MB_CNT_W-1:0]   mb_idx_reg;
  logic [MB_CNT_W-1:0]   mb_idx_inc;
  logic [BEAT_CNT_W-1:0] beat_reg;
  logic [BEAT_CNT_W-1:0] nbeats_reg;
  logic                  ready_reg;
  logic                  frame_done_reg;
  logic                  overrun_reg;
  logic                  last_beat;
  logic                  load_accept;

  // Holding registers for the captured bundle
  logic [31:0]   mode_i16_reg;
  logic [127:0]  mode_i4_reg;
  logic [31:0]   mode_uv_reg;
  logic [255:0]  dc_levels_reg;
  logic [4095:0] ac_levels_reg;
  logic [2047:0] uv_levels_reg;
  logic [7:0]    skipped_reg;
  logic [7:0]    mbtype_reg;
  logic [31:0]   nz_reg;

  logic [BEAT_W-1:0] beat_mux [BEATS_FULL];

  assign mb_idx_inc  = mb_idx_reg + MB_CNT_W'(1);
  assign last_beat   = (beat_reg == (nbeats_reg - BEAT_CNT_W'(1)));
  assign load_accept = (state_reg == ST_ARMED) && load;

  // Frame/macroblock sequencing FSM with registered ready/frame_done/overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      mb_total_reg   <= '0;
      mb_idx_reg     <= '0;
      beat_reg       <= '0;
      nbeats_reg     <= '0;
      ready_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (load && (state_reg != ST_ARMED)) begin
        overrun_reg <= 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (frame_start) begin
            mb_total_reg <= mb_total;
            mb_idx_reg   <= '0;
            overrun_reg  <= 1'b0;
            if (mb_total == '0) begin
              state_reg      <= ST_DONE;
              frame_done_reg <= 1'b1;
            end else begin
              state_reg <= ST_ARMED;
              ready_reg <= 1'b1;
            end
          end
        end
        ST_ARMED: begin
          if (load) begin
            beat_reg   <= '0;
            nbeats_reg <= ((SKIP_SHORT != 0) && skipped[0]) ?
                          BEAT_CNT_W'(BEATS_SKIP) : BEAT_CNT_W'(BEATS_FULL);
            state_reg  <= ST_SEND;
            ready_reg  <= 1'b0;
          end
        end
        ST_SEND: begin
          if (!fifo_full) begin
            if (last_beat) begin
              beat_reg   <= '0;
              mb_idx_reg <= mb_idx_inc;
              if (mb_idx_inc == mb_total_reg) begin
                state_reg      <= ST_DONE;
                frame_done_reg <= 1'b1;
              end else begin
                state_reg <= ST_ARMED;
                ready_reg <= 1'b1;
              end
            end else begin
              beat_reg <= beat_reg + BEAT_CNT_W'(1);
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Capture the full result bundle when a load is accepted in ARMED
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_i16_reg  <= '0;
      mode_i4_reg   <= '0;
      mode_uv_reg   <= '0;
      dc_levels_reg <= '0;
      ac_levels_reg <= '0;
      uv_levels_reg <= '0;
      skipped_reg   <= '0;
      mbtype_reg    <= '0;
      nz_reg        <= '0;
    end else if (load_accept) begin
      mode_i16_reg  <= mode_i16;
      mode_i4_reg   <= mode_i4;
      mode_uv_reg   <= mode_uv;
      dc_levels_reg <= dc_levels;
      ac_levels_reg <= ac_levels;
      uv_levels_reg <= uv_levels;
      skipped_reg   <= skipped;
      mbtype_reg    <= mbtype;
      nz_reg        <= nz;
    end
  end

  // Beat candidates: header, then luma AC slices, then chroma slices
  assign beat_mux[0] = build_header(32'(mb_idx_reg), mode_i16_reg, mode_i4_reg,
                                    mode_uv_reg, skipped_reg, mbtype_reg,
                                    nz_reg, dc_levels_reg);

  for (genvar gi = 0; gi < AC_BEATS; gi++) begin : g_ac_beat
    assign beat_mux[1 + gi] = ac_levels_reg[gi*BEAT_W +: BEAT_W];
  end

  for (genvar gi = 0; gi < UV_BEATS; gi++) begin : g_uv_beat
    assign beat_mux[1 + AC_BEATS + gi] = uv_levels_reg[gi*BEAT_W +: BEAT_W];
  end

  // Select the current beat; payload is forced to zero outside SEND
  always_comb begin
    data_out = '0;
    if ((state_reg == ST_SEND) && (beat_reg < BEAT_CNT_W'(BEATS_FULL))) begin
      data_out = beat_mux[beat_reg];
    end
  end

  assign fifo_wr    = (state_reg == ST_SEND) && !fifo_full;
  assign ready      = ready_reg;
  assign frame_done = frame_done_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_mb_result_writer.sv
// Directed + randomized bench for mb_result_writer with a beat-list model.
module tb_mb_result_writer;

  localparam int MBW = 20;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           frame_start;
  logic [MBW-1:0] mb_total;
  logic           load;
  logic [31:0]    mode_i16;
  logic [127:0]   mode_i4;
  logic [31:0]    mode_uv;
  logic [255:0]   dc_levels;
  logic [4095:0]  ac_levels;
  logic [2047:0]  uv_levels;
  logic [7:0]     skipped;
  logic [7:0]     mbtype;
  logic [31:0]    nz;
  logic           fifo_full;
  logic           ready;
  logic           fifo_wr;
  logic [1023:0]  data_out;
  logic           frame_done;
  logic           overrun;

  always #5 clk = ~clk;

  mb_result_writer #(.MB_CNT_W(MBW), .SKIP_SHORT(1)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .mb_total(mb_total),
    .load(load), .mode_i16(mode_i16), .mode_i4(mode_i4), .mode_uv(mode_uv),
    .dc_levels(dc_levels), .ac_levels(ac_levels), .uv_levels(uv_levels),
    .skipped(skipped), .mbtype(mbtype), .nz(nz), .fifo_full(fifo_full),
    .ready(ready), .fifo_wr(fifo_wr), .data_out(data_out),
    .frame_done(frame_done), .overrun(overrun)
  );

  typedef struct {
    logic [31:0]   i16;
    logic [127:0]  i4;
    logic [31:0]   uv;
    logic [255:0]  dc;
    logic [4095:0] ac;
    logic [2047:0] uvl;
    logic [7:0]    skp;
    logic [7:0]    typ;
    logic [31:0]   nz;
  } bundle_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc_n = 0;
  int            fd_cnt = 0;
  int            fd_cyc = -1;
  logic [1023:0] got_q[$];
  logic [1023:0] exp_q[$];
  int            got_cyc[$];
  bundle_t       bq[$];
  logic          last_fifo_wr;
  logic [1023:0] last_data;

  function automatic bundle_t rand_bundle(input bit skip);
    bundle_t b;
    b.i16 = $urandom;
    for (int i = 0; i < 4; i++)   b.i4[i*32 +: 32]  = $urandom;
    b.uv  = $urandom;
    for (int i = 0; i < 8; i++)   b.dc[i*32 +: 32]  = $urandom;
    for (int i = 0; i < 128; i++) b.ac[i*32 +: 32]  = $urandom;
    for (int i = 0; i < 64; i++)  b.uvl[i*32 +: 32] = $urandom;
    b.skp = {7'($urandom), skip};
    b.typ = 8'($urandom);
    b.nz  = $urandom;
    return b;
  endfunction

  // Reference: list of beats a macroblock must produce, from the field layout
  task automatic push_exp(input bundle_t b, input int idx);
    logic [1023:0] h;
    h = '0;
    h[31:0]    = 32'(idx);
    h[63:32]   = b.i16;
    h[191:64]  = b.i4;
    h[223:192] = b.uv;
    h[231:224] = b.skp;
    h[239:232] = b.typ;
    h[271:240] = b.nz;
    h[527:272] = b.dc;
    exp_q.push_back(h);
    if (!b.skp[0]) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(b.ac[k*1024 +: 1024]);
      for (int k = 0; k < 2; k++) exp_q.push_back(b.uvl[k*1024 +: 1024]);
    end
  endtask

  task automatic drive(input bundle_t b);
    mode_i16 = b.i16; mode_i4 = b.i4; mode_uv = b.uv; dc_levels = b.dc;
    ac_levels = b.ac; uv_levels = b.uvl; skipped = b.skp; mbtype = b.typ;
    nz = b.nz;
  endtask

  // One clock: sample outputs at negedge, advance to just after posedge
  task automatic step();
    @(negedge clk);
    if (fifo_wr === 1'b1) begin
      got_q.push_back(data_out);
      got_cyc.push_back(cyc_n);
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc_n;
    end
    last_fifo_wr = fifo_wr;
    last_data    = data_out;
    @(posedge clk);
    #1;
    cyc_n++;
    load = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    int w;
    w = 0;
    checks++;
    assert (obs === exp) else begin
      errors++;
      for (int i = 0; i < 32; i++) begin
        if (obs[i*32 +: 32] !== exp[i*32 +: 32]) begin
          w = i;
          break;
        end
      end
      $error("FAIL %s: word %0d observed=%h expected=%h", tag, w, obs[w*32 +: 32], exp[w*32 +: 32]);
    end
  endtask

  task automatic clear_obs();
    got_q.delete(); got_cyc.delete(); exp_q.delete();
    fd_cnt = 0; fd_cyc = -1;
  endtask

  task automatic cmp_stream(input string tag);
    int n;
    chk({tag, " beat count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk_vec($sformatf("%s beat%0d", tag, i), got_q[i], exp_q[i]);
    $display("%s: %0d beats written, %0d expected, frame_done x%0d", tag, got_q.size(), exp_q.size(), fd_cnt);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    int start;
    n = 0;
    start = fd_cnt;
    while (fd_cnt == start && n < budget) begin
      step();
      n++;
    end
    chk({tag, " frame_done seen"}, fd_cnt - start, 1);
  endtask

  // Whole frame from bq with random FIFO backpressure
  task automatic run_frame(input string tag, input int stall_pct);
    int n;
    clear_obs();
    mb_total = MBW'(bq.size());
    frame_start = 1'b1;
    step();
    for (int m = 0; m < bq.size(); m++) begin
      push_exp(bq[m], m);
      n = 0;
      while (ready !== 1'b1 && n < 100) begin
        fifo_full = ($urandom_range(99) < stall_pct);
        step();
        n++;
      end
      chk($sformatf("%s ready mb%0d", tag, m), ready, 1);
      drive(bq[m]);
      load = 1'b1;
      fifo_full = ($urandom_range(99) < stall_pct);
      step();
    end
    n = 0;
    while (fd_cnt == 0 && n < 200) begin
      fifo_full = ($urandom_range(99) < stall_pct);
      step();
      n++;
    end
    fifo_full = 1'b0;
    step();
    step();
    cmp_stream(tag);
    chk({tag, " frame_done count"}, fd_cnt, 1);
  endtask

  initial begin
    bundle_t b;
    bundle_t b2;
    int      load_cyc;
    int      n;
    int      total;

    rst_n = 1'b0; frame_start = 1'b0; mb_total = '0; load = 1'b0;
    fifo_full = 1'b0;
    drive(rand_bundle(1'b0));
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", ready, 0);
    chk("reset fifo_wr", fifo_wr, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset overrun", overrun, 0);
    chk_vec("reset data_out", data_out, '0);
    rst_n = 1'b1;
    step();

    // A: single full MB, unstalled, exact timing
    clear_obs();
    b = rand_bundle(1'b0);
    push_exp(b, 0);
    mb_total = 1;
    frame_start = 1'b1;
    step();
    chk("A ready after frame_start", ready, 1);
    drive(b);
    load = 1'b1;
    step();
    load_cyc = cyc_n - 1;
    wait_done("A", 40);
    cmp_stream("A");
    if (got_cyc.size() == 7) begin
      chk("A first beat cycle", got_cyc[0], load_cyc + 1);
      chk("A last beat cycle", got_cyc[6], load_cyc + 7);
    end
    chk("A frame_done cycle", fd_cyc, load_cyc + 8);
    chk("A ready after frame", ready, 0);

    // B: two MBs, second skipped -> header only
    bq.delete();
    bq.push_back(rand_bundle(1'b0));
    b = rand_bundle(1'b1);
    b.skp = 8'h01;
    bq.push_back(b);
    run_frame("B", 0);

    // C: five-cycle stall while beat 3 is presented
    clear_obs();
    b = rand_bundle(1'b0);
    push_exp(b, 0);
    mb_total = 1;
    frame_start = 1'b1;
    step();
    drive(b);
    load = 1'b1;
    step();
    n = 0;
    while (got_q.size() < 3 && n < 20) begin
      step();
      n++;
    end
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("C stall%0d fifo_wr", i), last_fifo_wr, 0);
      chk_vec($sformatf("C stall%0d data", i), last_data, exp_q[3]);
    end
    fifo_full = 1'b0;
    wait_done("C", 40);
    cmp_stream("C");

    // D: load during SEND is ignored and flags overrun
    clear_obs();
    b = rand_bundle(1'b0);
    b2 = rand_bundle(1'b0);
    push_exp(b, 0);
    mb_total = 1;
    frame_start = 1'b1;
    step();
    drive(b);
    load = 1'b1;
    step();
    chk("D overrun clear", overrun, 0);
    n = 0;
    while (got_q.size() < 2 && n < 20) begin
      step();
      n++;
    end
    drive(b2);
    load = 1'b1;
    step();
    chk("D overrun set", overrun, 1);
    wait_done("D", 40);
    cmp_stream("D");
    chk("D overrun sticky", overrun, 1);

    // E: empty frame clears overrun, finishes with no beats
    clear_obs();
    mb_total = 0;
    frame_start = 1'b1;
    step();
    chk("E overrun cleared", overrun, 0);
    wait_done("E", 3);
    step();
    chk("E no beats", got_q.size(), 0);
    chk("E frame_done once", fd_cnt, 1);

    // F: reset mid-MB during beat 2
    clear_obs();
    b = rand_bundle(1'b0);
    mb_total = 1;
    frame_start = 1'b1;
    step();
    drive(b);
    load = 1'b1;
    step();
    n = 0;
    while (got_q.size() < 2 && n < 20) begin
      step();
      n++;
    end
    rst_n = 1'b0;
    #1;
    chk("F rst fifo_wr", fifo_wr, 0);
    chk("F rst ready", ready, 0);
    chk("F rst frame_done", frame_done, 0);
    chk_vec("F rst data_out", data_out, '0);
    step();
    step();
    rst_n = 1'b1;
    n = got_q.size();
    for (int i = 0; i < 10; i++) step();
    chk("F no beats after reset", got_q.size(), n);
    chk("F ready idle", ready, 0);
    chk("F no frame_done", fd_cnt, 0);
    $display("F: reset during beat 2, %0d beats before reset", n);

    // R: randomized frames with random skips and backpressure
    for (int f = 0; f < 4; f++) begin
      bq.delete();
      total = $urandom_range(1, 3);
      for (int m = 0; m < total; m++) bq.push_back(rand_bundle(1'($urandom_range(1))));
      run_frame($sformatf("R%0d", f), 30);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
